// File: rtl/cosim_endpoint_tx_pkg.sv
// Shared message layout for the cosim host-bound transmitter.
// Generators and checkers build and split messages with the same helpers.
package Cosim_TxPkg;

  localparam int unsigned SENT_COUNT_W = 32;
  localparam int unsigned MSG_MAX_W    = 64;

  typedef logic [MSG_MAX_W-1:0] msg_word_t;

  function automatic msg_word_t field_mask(input int unsigned bits);
    msg_word_t one;
    one = msg_word_t'(1);
    return (one << bits) - one;
  endfunction

  // Message = {seq, payload}; payload occupies the low payload_bits.
  function automatic msg_word_t make_msg(input msg_word_t seq,
                                         input msg_word_t payload,
                                         input int unsigned payload_bits);
    return (seq << payload_bits) | (payload & field_mask(payload_bits));
  endfunction

  function automatic msg_word_t msg_seq(input msg_word_t msg,
                                        input int unsigned payload_bits,
                                        input int unsigned seq_bits);
    return (msg >> payload_bits) & field_mask(seq_bits);
  endfunction

  function automatic msg_word_t msg_payload(input msg_word_t msg,
                                            input int unsigned payload_bits);
    return msg & field_mask(payload_bits);
  endfunction

endpackage

// File: rtl/cosim_endpoint_tx_fifo.sv
// Synchronous FIFO with extra-bit pointers, occupancy level and a
// synchronous clear that overrides push and pop.
module cosim_tx_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               push_ok, pop_ok;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (level_o == (PTR_W+1)'(DEPTH));

  assign push_ok = push_i && !full_o && !clear_i;
  assign pop_ok  = pop_i && !empty_o && !clear_i;

  // Head is forced to zero while empty so the output is defined after reset.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/cosim_endpoint_tx.sv
// Host-bound cosim transmitter: stamps local payloads with a wrapping
// sequence number, buffers them and presents them on DataIn/DataInValid.
module cosim_endpoint_tx
  import Cosim_TxPkg::*;
#(
  parameter int TYPE_SIZE_BITS = 24,
  parameter int SEQ_BITS       = 8,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                SrcValid,
  output logic                                SrcReady,
  input  logic [TYPE_SIZE_BITS-SEQ_BITS-1:0]  SrcData,
  input  logic                                Flush,
  output logic                                DataInValid,
  input  logic                                DataInReady,
  output logic [TYPE_SIZE_BITS-1:0]           DataIn,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     Level,
  output logic [SENT_COUNT_W-1:0]             SentCount
);

  localparam int unsigned PAYLOAD_BITS = TYPE_SIZE_BITS - SEQ_BITS;

  logic [SEQ_BITS-1:0]       seq_q, seq_d;
  logic [SENT_COUNT_W-1:0]   sent_q, sent_d;
  logic [TYPE_SIZE_BITS-1:0] wr_msg;
  msg_word_t                 msg_full;
  logic                      fifo_full, fifo_empty;
  logic                      push, pop;

  assign msg_full = make_msg(msg_word_t'(seq_q), msg_word_t'(SrcData), PAYLOAD_BITS);
  assign wr_msg   = msg_full[TYPE_SIZE_BITS-1:0];

  // Ready depends only on occupancy, so a full FIFO refuses even during a pop.
  assign SrcReady    = !fifo_full;
  assign DataInValid = !fifo_empty;

  assign push = SrcValid && SrcReady && !Flush;
  assign pop  = DataInValid && DataInReady && !Flush;

  cosim_tx_fifo #(
    .WIDTH (TYPE_SIZE_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (Flush),
    .push_i  (push),
    .wdata_i (wr_msg),
    .pop_i   (pop),
    .rdata_o (DataIn),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (Level)
  );

  always_comb begin
    seq_d  = seq_q;
    sent_d = sent_q;
    if (Flush) begin
      seq_d = '0;
    end else if (push) begin
      seq_d = seq_q + 1'b1;
    end
    if (pop && (sent_q != '1)) sent_d = sent_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q  <= '0;
      sent_q <= '0;
    end else begin
      seq_q  <= seq_d;
      sent_q <= sent_d;
    end
  end

  assign SentCount = sent_q;

endmodule

// File: tb/tb_cosim_endpoint_tx.sv
// Self-checking bench for cosim_endpoint_tx: vector table, scoreboard of
// stamped messages, and directed backpressure/wrap/flush/reset sequences.
module tb_cosim_endpoint_tx;

  localparam int TSB = 24;
  localparam int SB  = 8;
  localparam int PB  = TSB - SB;
  localparam int D   = 4;

  logic           clk;
  logic           rst;
  logic           SrcValid;
  logic           SrcReady;
  logic [PB-1:0]  SrcData;
  logic           Flush;
  logic           DataInValid;
  logic           DataInReady;
  logic [TSB-1:0] DataIn;
  logic [2:0]     Level;
  logic [31:0]    SentCount;

  cosim_endpoint_tx #(
    .TYPE_SIZE_BITS (TSB),
    .SEQ_BITS       (SB),
    .FIFO_DEPTH     (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .SrcValid    (SrcValid),
    .SrcReady    (SrcReady),
    .SrcData     (SrcData),
    .Flush       (Flush),
    .DataInValid (DataInValid),
    .DataInReady (DataInReady),
    .DataIn      (DataIn),
    .Level       (Level),
    .SentCount   (SentCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [TSB-1:0] exp_q[$];
  logic [SB-1:0]  seq_m = '0;

  typedef struct {
    logic [PB-1:0]  payload;
    logic [TSB-1:0] exp_msg;
  } vec_t;

  vec_t vecs[3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
  endtask

  // Scoreboard: accepted payloads are stamped by the bench's own sequence
  // counter; every endpoint acceptance must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (Flush) begin
        exp_q.delete();
        seq_m = '0;
      end else begin
        if (DataInValid && DataInReady) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_underflow: got message %0h expected none", DataIn);
          end else begin
            check("sb_data", 64'(DataIn), 64'(exp_q.pop_front()));
          end
        end
        if (SrcValid && SrcReady) begin
          exp_q.push_back({seq_m, SrcData});
          seq_m = seq_m + 1'b1;
        end
      end
    end
  end

  initial begin
    vecs[0] = '{16'h0001, 24'h000001};
    vecs[1] = '{16'h0002, 24'h010002};
    vecs[2] = '{16'h0003, 24'h020003};

    rst = 1'b1; SrcValid = 1'b0; SrcData = '0; Flush = 1'b0; DataInReady = 1'b0;

    // Reset state, before any clock edge
    #3;
    check("rst_valid", 64'(DataInValid), 64'd0);
    check("rst_ready", 64'(SrcReady), 64'd1);
    check("rst_level", 64'(Level), 64'd0);
    check("rst_sent",  64'(SentCount), 64'd0);
    check("rst_data",  64'(DataIn), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    check("idle_valid", 64'(DataInValid), 64'd0);
    check("idle_level", 64'(Level), 64'd0);

    // Streaming with endpoint always ready
    DataInReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      SrcValid = 1'b1;
      SrcData  = vecs[i].payload;
      tick();
      check("vec_valid", 64'(DataInValid), 64'd1);
      check("vec_data",  64'(DataIn), 64'(vecs[i].exp_msg));
    end
    SrcValid = 1'b0;
    tick();
    check("vec_level", 64'(Level), 64'd0);
    check("vec_sent",  64'(SentCount), 64'd3);
    check("vec_empty_valid", 64'(DataInValid), 64'd0);

    // Backpressure: fill to full, fifth payload refused, head held stable
    do_flush();
    DataInReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      SrcValid = 1'b1;
      SrcData  = PB'(16'h0100 + i);
      if (i == 4) begin
        check("bp_ready_full", 64'(SrcReady), 64'd0);
        check("bp_level_full", 64'(Level), 64'd4);
      end
      tick();
      check("bp_head_stable", 64'(DataIn), 64'h000100);
      check("bp_valid_hold",  64'(DataInValid), 64'd1);
    end
    SrcValid = 1'b0;
    check("bp_level_hold", 64'(Level), 64'd4);
    DataInReady = 1'b1;
    repeat (4) tick();
    check("bp_drained", 64'(Level), 64'd0);
    check("bp_sent",    64'(SentCount), 64'd7);

    // Sequence wrap over 257 messages
    do_flush();
    for (int i = 0; i < 257; i++) begin
      SrcValid = 1'b1;
      SrcData  = PB'(i);
      tick();
      if (i == 255) check("wrap_seq_ff", 64'(DataIn), 64'hFF00FF);
      if (i == 256) check("wrap_seq_00", 64'(DataIn), 64'h000100);
    end
    SrcValid = 1'b0;
    tick();
    check("wrap_level", 64'(Level), 64'd0);
    check("wrap_sent",  64'(SentCount), 64'd264);

    // Flush with Level=3 colliding with a push and a pop
    DataInReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      SrcValid = 1'b1;
      SrcData  = PB'(16'h00A0 + i);
      tick();
    end
    SrcValid = 1'b0;
    check("fl_level_pre", 64'(Level), 64'd3);
    Flush = 1'b1; SrcValid = 1'b1; SrcData = 16'hBEEF; DataInReady = 1'b1;
    tick();
    Flush = 1'b0; SrcValid = 1'b0;
    check("fl_level",   64'(Level), 64'd0);
    check("fl_valid",   64'(DataInValid), 64'd0);
    check("fl_ready",   64'(SrcReady), 64'd1);
    check("fl_sent",    64'(SentCount), 64'd264);
    SrcValid = 1'b1; SrcData = 16'h5555;
    tick();
    SrcValid = 1'b0;
    check("fl_seq0", 64'(DataIn), 64'h005555);
    tick();
    check("fl_sent_after", 64'(SentCount), 64'd265);

    // Asynchronous reset with two messages in flight
    DataInReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      SrcValid = 1'b1;
      SrcData  = PB'(16'h0011 * (i + 1));
      tick();
    end
    SrcValid = 1'b0;
    check("ar_level_pre", 64'(Level), 64'd2);
    #2 rst = 1'b1;
    exp_q.delete();
    seq_m = '0;
    #1;
    check("ar_valid", 64'(DataInValid), 64'd0);
    check("ar_level", 64'(Level), 64'd0);
    check("ar_ready", 64'(SrcReady), 64'd1);
    check("ar_data",  64'(DataIn), 64'd0);
    check("ar_sent",  64'(SentCount), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    SrcValid = 1'b1; SrcData = 16'h7777;
    tick();
    SrcValid = 1'b0;
    check("ar_seq0", 64'(DataIn), 64'h007777);
    DataInReady = 1'b1;
    tick();
    check("ar_drain_level", 64'(Level), 64'd0);
    check("ar_drain_sent",  64'(SentCount), 64'd1);
    check("sb_left", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
